// File: rtl/seven_segment_scan_controller.sv
// seven_segment_scan_controller
// Time-multiplexed scan controller for a bank of common-anode seven-segment
// digits. Shadow copies of the per-digit nibble, decimal point and enable are
// updated only at frame boundaries, through a level request / pulse
// acknowledge handshake, so a frame never mixes old and new data. Every digit
// slot starts with a blanking interval (all anodes off) and then has an
// active interval.
//
// Ports:
//   clock           sole clock, rising edge
//   resetN          asynchronous active-low reset
//   value           4*DIGIT_COUNT packed nibbles, digit i = value[4i+3:4i]
//   pointEnable     decimal point per digit
//   digitEnable     1 = digit lit, 0 = anode held off
//   loadRequest     level request to capture value/pointEnable/digitEnable
//   loadAcknowledge one-cycle pulse after the capture edge
//   encodedValue    nibble to the downstream encoder
//   encodedPoint    decimal point to the downstream encoder
//   anodeEnableN    active-low digit select
//   frameStart      one-cycle pulse at the start of each digit-0 active phase
module seven_segment_scan_controller #(
  parameter int DIGIT_COUNT  = 4,
  parameter int DIGIT_PERIOD = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic [4*DIGIT_COUNT-1:0] value,
  input  logic [DIGIT_COUNT-1:0]   pointEnable,
  input  logic [DIGIT_COUNT-1:0]   digitEnable,
  input  logic                     loadRequest,
  output logic                     loadAcknowledge,
  output logic [3:0]               encodedValue,
  output logic                     encodedPoint,
  output logic [DIGIT_COUNT-1:0]   anodeEnableN,
  output logic                     frameStart
);

  localparam int CW = $clog2(DIGIT_PERIOD);
  localparam int IW = $clog2(DIGIT_COUNT);
  localparam logic [CW-1:0] BLANK_LAST  = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] ACTIVE_LAST = CW'(DIGIT_PERIOD - BLANK_CYCLES - 1);
  localparam logic [IW-1:0] INDEX_LAST  = IW'(DIGIT_COUNT - 1);

  typedef enum logic {BLANK, ACTIVE} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx;
  logic [4*DIGIT_COUNT-1:0] sh_value;
  logic [DIGIT_COUNT-1:0]   sh_point;
  logic [DIGIT_COUNT-1:0]   sh_enable;

  logic                     boundary;
  logic                     take_new;
  logic [4*DIGIT_COUNT-1:0] src_value;
  logic [DIGIT_COUNT-1:0]   src_point;
  logic [DIGIT_COUNT-1:0]   src_enable;
  logic [3:0]               sel_value;
  logic                     sel_point;
  logic [DIGIT_COUNT-1:0]   sel_anode;

  // On a capturing boundary edge the outputs are fed straight from the inputs,
  // so the freshly loaded digit 0 appears on the same edge as the capture.
  always_comb begin
    boundary   = (state == BLANK) && (cnt == BLANK_LAST) && (idx == '0);
    take_new   = boundary && loadRequest;
    src_value  = take_new ? value       : sh_value;
    src_point  = take_new ? pointEnable : sh_point;
    src_enable = take_new ? digitEnable : sh_enable;
    sel_value  = '0;
    sel_point  = 1'b0;
    sel_anode  = '1;
    for (int unsigned i = 0; i < DIGIT_COUNT; i++) begin
      if (idx == IW'(i)) begin
        sel_value    = src_value[4*i +: 4];
        sel_point    = src_point[i];
        sel_anode[i] = ~src_enable[i];
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state           <= BLANK;
      cnt             <= '0;
      idx             <= '0;
      sh_value        <= '0;
      sh_point        <= '0;
      sh_enable       <= '0;
      loadAcknowledge <= 1'b0;
      frameStart      <= 1'b0;
      encodedValue    <= '0;
      encodedPoint    <= 1'b0;
      anodeEnableN    <= '1;
    end else begin
      loadAcknowledge <= 1'b0;
      frameStart      <= 1'b0;
      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state        <= ACTIVE;
            cnt          <= '0;
            encodedValue <= sel_value;
            encodedPoint <= sel_point;
            anodeEnableN <= sel_anode;
            if (boundary) begin
              frameStart <= 1'b1;
            end
            if (take_new) begin
              sh_value        <= value;
              sh_point        <= pointEnable;
              sh_enable       <= digitEnable;
              loadAcknowledge <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACTIVE: begin
          if (cnt == ACTIVE_LAST) begin
            state        <= BLANK;
            cnt          <= '0;
            anodeEnableN <= '1;
            idx          <= (idx == INDEX_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= BLANK;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/seven_segment_scan_controller.md
# seven_segment_scan_controller

Time-multiplexed scan controller for a bank of common-anode seven-segment digits. It holds a shadow copy of one hex nibble, one decimal-point bit and one enable bit per digit. It steps through the digits one at a time, feeding the selected nibble and point to a downstream `SevenSegmentEncoder` and driving the matching active-low anode. A blanking interval between digits prevents ghosting. New display data is accepted through a request/acknowledge handshake, only at frame boundaries, so a frame never mixes old and new data.

## Interface
- `DIGIT_COUNT`, 4: number of digits scanned; ≥ 2.
- `DIGIT_PERIOD`, 50000: clock cycles per digit slot, blank plus active; must exceed `BLANK_CYCLES`.
- `BLANK_CYCLES`, 500: cycles per slot with all anodes off; ≥ 1.
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `value`  in  4·DIGIT_COUNT  digit i nibble is `value[4i+3:4i]`.
- `pointEnable`  in  DIGIT_COUNT  decimal point for digit i.
- `digitEnable`  in  DIGIT_COUNT  1 = digit i lit, 0 = anode held off.
- `loadRequest`  in  1  request to capture `value`/`pointEnable`/`digitEnable`; level, held until acknowledged.
- `loadAcknowledge`  out  1  one-cycle pulse: capture occurred.
- `encodedValue`  out  4  nibble to the encoder `value` input.
- `encodedPoint`  out  1  to the encoder `pointEnable` input.
- `anodeEnableN`  out  DIGIT_COUNT  active-low digit select.
- `frameStart`  out  1  one-cycle pulse at the start of each digit-0 active phase.

## Operation
- FSM with two states: BLANK and ACTIVE. A phase counter of width `$clog2(DIGIT_PERIOD)` runs 0..BLANK_CYCLES−1 in BLANK and 0..DIGIT_PERIOD−BLANK_CYCLES−1 in ACTIVE. A digit index counter runs 0..DIGIT_COUNT−1.
- BLANK → ACTIVE on the edge where the counter reaches BLANK_CYCLES−1. Counter clears to 0.
- ACTIVE → BLANK on the edge where the counter reaches its last value. Counter clears to 0. Index increments and wraps from DIGIT_COUNT−1 to 0.
- In BLANK, `anodeEnableN` is all ones.
- In ACTIVE, `anodeEnableN[index]` = ~shadowDigitEnable[index]. All other bits are 1.
- `encodedValue` and `encodedPoint` are registered and load on the BLANK→ACTIVE edge from the shadow entry for the current index. They hold through the following BLANK.
- Frame boundary edge: the BLANK→ACTIVE edge while index = 0. This is the only point at which shadow registers change.
- If `loadRequest`=1 on the frame boundary edge:
  - The shadow registers capture all three inputs.
  - `loadAcknowledge`=1 for exactly the next cycle.
  - `encodedValue`/`encodedPoint` and the anode take the newly captured digit-0 data on that same edge, with no stale frame.
- `loadRequest` deasserted before a boundary edge: no capture, no acknowledge.
- `loadRequest` still high at a later boundary edge: captures again and acknowledges again. The requester drops it after the acknowledge.
- Inputs are sampled only on the boundary edge. Changes at other times have no effect.
- `frameStart`=1 for the cycle following every frame boundary edge, whether or not a load occurred.

## Timing
- Reset (asynchronous, immediate) values:
  - state BLANK, counter 0, index 0.
  - All shadow registers 0, so the display is dark.
  - `anodeEnableN` all ones.
  - `encodedValue`=0, `encodedPoint`=0, `loadAcknowledge`=0, `frameStart`=0.
- Reset asserted mid-operation overrides everything, including a pending acknowledge. On release, the scan restarts with digit 0 BLANK.
- First boundary edge after reset release: rising edge number BLANK_CYCLES. A request held through reset is captured there.
- Slot length is DIGIT_PERIOD cycles. Frame length is DIGIT_COUNT·DIGIT_PERIOD cycles, so `frameStart` is periodic with that spacing.
- Load latency: 1 to DIGIT_COUNT·DIGIT_PERIOD cycles from request to acknowledge. New data is visible in the same cycle as `loadAcknowledge`.
- Anode and encoder outputs change on the same edge. Anodes are never low during BLANK.

## Test plan
All scenarios use DIGIT_COUNT=4, DIGIT_PERIOD=8, BLANK_CYCLES=2.
- Reset, then idle 64 cycles:
  - `anodeEnableN`=4'b1111 throughout.
  - `frameStart` pulses after edges 2, 34.
  - `loadAcknowledge` stays 0.
- `loadRequest`=1 from reset, `value`=16'h4321, `digitEnable`=4'b1111, `pointEnable`=4'b0100:
  - `loadAcknowledge` and `frameStart` high in cycle 2.
  - Cycles 2–7: anodes 4'b1110, `encodedValue`=1.
  - Cycles 8–9: anodes 4'b1111.
  - Cycles 10–15: 4'b1101 with value 2.
  - Digit 2 slot: `encodedPoint`=1.
- Load `digitEnable`=4'b0101: digits 1 and 3 slots keep anodes 4'b1111 while `encodedValue` still steps through their nibbles.
- Request 16'hABCD at cycle 10, during a frame showing 16'h4321:
  - Digits 1–3 of the current frame still show 2, 3, 4.
  - `loadAcknowledge` in cycle 34, with `encodedValue`=4'hD.
- Assert `resetN`=0 during the digit-2 active phase: outputs return immediately to reset values, and shadow data is lost.
- `loadRequest` held high for 3 frames: acknowledge pulses in cycles 2, 34, 66, each one cycle wide.
